// File: rtl/flash_boot_copier.sv
// flash_boot_copier: copies QWORDS qwords from the SPI read window into buffer RAM over the
// flash controller request port, and passes host traffic straight through whenever it is idle.
module flash_boot_copier #(
  parameter logic [31:0] SRC_BASE = 32'h2000_0000,
  parameter logic [31:0] DST_BASE = 32'h0000_0000,
  parameter int unsigned QWORDS   = 8064,
  parameter logic [20:0] RD_TAG   = 21'h03_0000,
  parameter int unsigned TIMEOUT  = 4095,
  parameter bit          AUTOBOOT = 1'b1
) (
  input  logic        CLKH,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  input  logic        H_ACT,
  input  logic        H_CMD,
  input  logic [31:0] H_ADDR,
  input  logic [7:0]  H_BE,
  input  logic [63:0] H_DTI,
  input  logic [20:0] H_TAGI,
  output logic        H_NEXT,
  output logic        H_DRDY,
  output logic [63:0] H_DTO,
  output logic [20:0] H_TAGO,
  output logic        F_ACT,
  output logic        F_CMD,
  output logic [31:0] F_ADDR,
  output logic [7:0]  F_BE,
  output logic [63:0] F_DTI,
  output logic [20:0] F_TAGI,
  input  logic        F_NEXT,
  input  logic        F_DRDY,
  input  logic [63:0] F_DTO,
  input  logic [20:0] F_TAGO
);

  typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ} state_t;

  localparam logic [12:0] LAST_IDX = 13'(QWORDS - 1);
  localparam logic [12:0] WAIT_MAX = 13'(TIMEOUT);

  state_t      state_q, state_d;
  logic [12:0] idx_q, idx_d;
  logic [12:0] wcnt_q, wcnt_d;
  logic [63:0] dbuf_q, dbuf_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        start_lat_q, start_lat_d;
  logic        boot_q, boot_d;

  logic        busy;
  logic        start_req;
  logic        host_rd_xfer;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;

  assign busy         = (state_q != S_IDLE);
  assign start_req    = (START && !busy) || boot_q || start_lat_q;
  assign host_rd_xfer = !busy && H_ACT && H_CMD && F_NEXT;
  assign src_addr     = SRC_BASE + {16'd0, idx_q, 3'd0};
  assign dst_addr     = DST_BASE + {16'd0, idx_q, 3'd0};

  always_ff @(posedge CLKH or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      dbuf_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      start_lat_q <= 1'b0;
      boot_q      <= AUTOBOOT;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      dbuf_q      <= dbuf_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      start_lat_q <= start_lat_d;
      boot_q      <= boot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    dbuf_d      = dbuf_q;
    done_d      = done_q;
    err_d       = err_q;
    start_lat_d = start_lat_q;
    boot_d      = 1'b0;
    // A new host read in the same cycle as an old response keeps the flag set.
    pend_d      = pend_q;
    if (F_DRDY)       pend_d = 1'b0;
    if (host_rd_xfer) pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (!pend_q) begin
            state_d     = S_RD_REQ;
            idx_d       = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            start_lat_d = 1'b0;
          end else begin
            start_lat_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        wcnt_d = '0;
        if (F_NEXT) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (F_DRDY && (F_TAGO == RD_TAG)) begin
          dbuf_d  = F_DTO;
          state_d = S_WR_REQ;
        end else if (wcnt_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 13'd1;
        end
      end
      S_WR_REQ: begin
        if (F_NEXT) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 13'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    F_ACT  = H_ACT;
    F_CMD  = H_CMD;
    F_ADDR = H_ADDR;
    F_BE   = H_BE;
    F_DTI  = H_DTI;
    F_TAGI = H_TAGI;
    H_NEXT = F_NEXT;
    H_DRDY = F_DRDY;
    if (busy) begin
      H_NEXT = 1'b0;
      H_DRDY = 1'b0;
      F_ACT  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
      F_BE   = 8'h00;
      if (state_q == S_WR_REQ) begin
        F_CMD  = 1'b0;
        F_ADDR = dst_addr;
        F_DTI  = dbuf_q;
        F_TAGI = '0;
      end else begin
        F_CMD  = 1'b1;
        F_ADDR = src_addr;
        F_DTI  = '0;
        F_TAGI = RD_TAG;
      end
    end
  end

  assign H_DTO = F_DTO;
  assign H_TAGO = F_TAGO;
  assign BUSY  = busy;
  assign DONE  = done_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: a flash controller model answers reads, logs every transfer,
// and each scenario task compares the logs against the expected copy sequence.
module tb_flash_boot_copier;

  localparam logic [31:0] SRC = 32'h2000_0000;
  localparam logic [31:0] DST = 32'h0000_0000;
  localparam int          NQ  = 4;
  localparam int          TMO = 100;
  localparam logic [20:0] RDT = 21'h03_0000;

  logic        CLKH = 1'b0, RESET = 1'b1, START = 1'b0;
  logic        BUSY, DONE, ERR;
  logic        H_ACT = 1'b0, H_CMD = 1'b0;
  logic [31:0] H_ADDR = '0;
  logic [7:0]  H_BE = '0;
  logic [63:0] H_DTI = '0;
  logic [20:0] H_TAGI = '0;
  logic        H_NEXT, H_DRDY;
  logic [63:0] H_DTO;
  logic [20:0] H_TAGO;
  logic        F_ACT, F_CMD;
  logic [31:0] F_ADDR;
  logic [7:0]  F_BE;
  logic [63:0] F_DTI;
  logic [20:0] F_TAGI;
  logic        F_NEXT = 1'b1, F_DRDY = 1'b0;
  logic [63:0] F_DTO = '0;
  logic [20:0] F_TAGO = '0;

  flash_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .QWORDS(NQ), .RD_TAG(RDT),
                      .TIMEOUT(TMO), .AUTOBOOT(1'b1)) dut (
    .CLKH(CLKH), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .H_ACT(H_ACT), .H_CMD(H_CMD), .H_ADDR(H_ADDR), .H_BE(H_BE), .H_DTI(H_DTI), .H_TAGI(H_TAGI),
    .H_NEXT(H_NEXT), .H_DRDY(H_DRDY), .H_DTO(H_DTO), .H_TAGO(H_TAGO),
    .F_ACT(F_ACT), .F_CMD(F_CMD), .F_ADDR(F_ADDR), .F_BE(F_BE), .F_DTI(F_DTI), .F_TAGI(F_TAGI),
    .F_NEXT(F_NEXT), .F_DRDY(F_DRDY), .F_DTO(F_DTO), .F_TAGO(F_TAGO)
  );

  always #5 CLKH = ~CLKH;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int lat = 20, host_lat = 30, resp_mode = 0;
  bit bp_mode = 0, fnext_ovr = 0, fnext_val = 1'b1;
  int bp_cnt = 0, stall_cnt = 0, stab_err = 0, attr_err = 0, hnext_viol = 0, hdrdy_viol = 0;
  logic [31:0] seed = 32'h1234_5678;
  bit          stall_prev = 0;
  logic [31:0] p_addr;
  logic [63:0] p_dti;
  logic        p_cmd;

  logic [63:0] rdat_at [int];
  logic [20:0] rtag_at [int];
  logic [31:0] rd_addr_q [$];
  int          rd_cyc_q [$];
  logic [31:0] wr_addr_q [$];
  logic [63:0] wr_data_q [$];
  int          wr_cyc_q [$];

  // Contents of the flash read window: any address maps to a seed-dependent pattern.
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a ^ seed, ~a};
  endfunction

  always @(posedge CLKH) begin
    cyc = cyc + 1;
    #1;
    if (rdat_at.exists(cyc)) begin
      F_DRDY = 1'b1;
      F_DTO  = rdat_at[cyc];
      F_TAGO = rtag_at[cyc];
      rdat_at.delete(cyc);
      rtag_at.delete(cyc);
    end else begin
      F_DRDY = 1'b0;
      F_DTO  = {$urandom, $urandom};
      F_TAGO = 21'($urandom);
    end
    if (fnext_ovr) F_NEXT = fnext_val;
    else if (bp_mode && BUSY && F_ACT && bp_cnt < 7) begin
      F_NEXT = 1'b0;
      bp_cnt++;
      stall_cnt++;
    end else F_NEXT = 1'b1;
  end

  always @(negedge CLKH) begin
    if (RESET) begin
      rdat_at.delete();
      rtag_at.delete();
      stall_prev = 0;
    end else begin
      if (BUSY && H_NEXT) hnext_viol++;
      if (BUSY && H_DRDY) hdrdy_viol++;
      if (stall_prev && BUSY && F_ACT && (F_ADDR !== p_addr || F_DTI !== p_dti || F_CMD !== p_cmd))
        stab_err++;
      stall_prev = BUSY && F_ACT && !F_NEXT;
      p_addr = F_ADDR; p_dti = F_DTI; p_cmd = F_CMD;
      if (F_ACT && F_NEXT) begin
        if (BUSY) begin
          bp_cnt = 0;
          if (F_CMD) begin
            rd_addr_q.push_back(F_ADDR);
            rd_cyc_q.push_back(cyc);
            if (F_BE !== 8'h00 || F_TAGI !== RDT || F_DTI !== 64'h0) attr_err++;
            case (resp_mode)
              1: begin
                rdat_at[cyc+lat-3] = 64'h1111; rtag_at[cyc+lat-3] = 21'h0;
                rdat_at[cyc+lat]   = 64'hAAAA; rtag_at[cyc+lat]   = RDT;
                resp_mode = 0;
              end
              2: begin
                rdat_at[cyc+TMO+20] = mem_data(F_ADDR); rtag_at[cyc+TMO+20] = RDT;
                resp_mode = 0;
              end
              default: begin
                rdat_at[cyc+lat] = mem_data(F_ADDR); rtag_at[cyc+lat] = RDT;
              end
            endcase
          end else begin
            wr_addr_q.push_back(F_ADDR);
            wr_data_q.push_back(F_DTI);
            wr_cyc_q.push_back(cyc);
            if (F_BE !== 8'h00 || F_TAGI !== 21'h0) attr_err++;
          end
        end else if (F_CMD) begin
          rdat_at[cyc+host_lat] = mem_data(F_ADDR);
          rtag_at[cyc+host_lat] = F_TAGI;
        end
      end
    end
  end

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge CLKH); #1 START = 1'b1;
    @(posedge CLKH); #1 START = 1'b0;
  endtask

  task automatic wait_busy(input int bound, output bit tmo);
    tmo = 1;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLKH);
      if (BUSY) begin tmo = 0; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit tmo);
    tmo = 1;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLKH);
      if (!BUSY) begin tmo = 0; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] a;
    a = $urandom;
    #1 H_ACT = 1'b1; H_CMD = 1'b0; H_ADDR = a;
    fnext_ovr = 1; fnext_val = 1'b0;
    @(posedge CLKH); @(negedge CLKH);
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
    n_checks++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else n_pass++;
    n_checks++; if (ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", ERR); else n_pass++;
    n_checks++; if (F_ACT !== 1'b1 || F_ADDR !== a)
      $display("FAIL reset_passthru: got act=%b addr=%h want act=1 addr=%h", F_ACT, F_ADDR, a); else n_pass++;
    n_checks++; if (H_NEXT !== 1'b0) $display("FAIL reset_hnext_lo: got %b want 0", H_NEXT); else n_pass++;
    fnext_val = 1'b1;
    @(posedge CLKH); @(negedge CLKH);
    n_checks++; if (H_NEXT !== 1'b1) $display("FAIL reset_hnext_hi: got %b want 1", H_NEXT); else n_pass++;
    @(posedge CLKH); #1 H_ACT = 1'b0; fnext_ovr = 0;
    @(negedge CLKH);
    n_checks++; if (F_ACT !== 1'b0) $display("FAIL reset_fact: got %b want 0", F_ACT); else n_pass++;
  endtask

  task automatic test_autoboot();
    bit tmo;
    int order_err = 0, lat_err = 0;
    clear_logs(); seed = $urandom; lat = 20;
    @(posedge CLKH); #1 RESET = 1'b0;
    wait_busy(5, tmo);
    n_checks++; if (tmo) $display("FAIL autoboot_start: got busy=0 want busy=1 within 5 cycles"); else n_pass++;
    wait_idle(2000, tmo);
    n_checks++; if (tmo) $display("FAIL autoboot_finish: got busy=1 want busy=0 within 2000 cycles"); else n_pass++;
    n_checks++; if (DONE !== 1'b1 || ERR !== 1'b0)
      $display("FAIL autoboot_flags: got done=%b err=%b want done=1 err=0", DONE, ERR); else n_pass++;
    n_checks++; if (rd_addr_q.size() != NQ || wr_addr_q.size() != NQ)
      $display("FAIL autoboot_counts: got rd=%0d wr=%0d want %0d", rd_addr_q.size(), wr_addr_q.size(), NQ); else n_pass++;
    n_checks++; if (wr_cyc_q.size() == 0 || cyc !== wr_cyc_q[$] + 1)
      $display("FAIL autoboot_done_timing: got cyc=%0d want last write cyc+1", cyc); else n_pass++;
    for (int i = 0; i < NQ && i < rd_addr_q.size() && i < wr_addr_q.size(); i++) begin
      n_checks++; if (rd_addr_q[i] !== SRC + 32'(8*i))
        $display("FAIL autoboot_rd_addr%0d: got %h want %h", i, rd_addr_q[i], SRC + 32'(8*i)); else n_pass++;
      n_checks++; if (wr_addr_q[i] !== DST + 32'(8*i) || wr_data_q[i] !== mem_data(SRC + 32'(8*i)))
        $display("FAIL autoboot_wr%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i],
                 DST + 32'(8*i), mem_data(SRC + 32'(8*i))); else n_pass++;
      if (wr_cyc_q[i] - rd_cyc_q[i] != lat + 1) lat_err++;
      if (wr_cyc_q[i] <= rd_cyc_q[i] || (i > 0 && rd_cyc_q[i] <= wr_cyc_q[i-1])) order_err++;
    end
    n_checks++; if (order_err != 0 || lat_err != 0)
      $display("FAIL autoboot_sequence: got order_err=%0d lat_err=%0d want 0", order_err, lat_err); else n_pass++;
    n_checks++; if (attr_err != 0) $display("FAIL autoboot_attrs: got %0d bad requests want 0", attr_err); else n_pass++;
    n_checks++; if (hnext_viol != 0) $display("FAIL autoboot_hnext: got %0d busy cycles with H_NEXT want 0", hnext_viol); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit tmo;
    clear_logs(); seed = $urandom; lat = $urandom_range(8, 40);
    bp_mode = 1; stall_cnt = 0; stab_err = 0;
    pulse_start();
    n_checks++; if (BUSY !== 1'b1 || F_ACT !== 1'b1 || DONE !== 1'b0)
      $display("FAIL bp_start: got busy=%b act=%b done=%b want 1 1 0", BUSY, F_ACT, DONE); else n_pass++;
    wait_idle(3000, tmo);
    bp_mode = 0;
    n_checks++; if (tmo || DONE !== 1'b1) $display("FAIL bp_finish: got tmo=%b done=%b want 0 1", tmo, DONE); else n_pass++;
    n_checks++; if (stall_cnt != 2*NQ*7) $display("FAIL bp_stalls: got %0d want %0d", stall_cnt, 2*NQ*7); else n_pass++;
    n_checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err); else n_pass++;
    n_checks++; if (rd_addr_q.size() != NQ || wr_addr_q.size() != NQ)
      $display("FAIL bp_counts: got rd=%0d wr=%0d want %0d", rd_addr_q.size(), wr_addr_q.size(), NQ); else n_pass++;
    for (int i = 0; i < NQ && i < wr_addr_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== DST + 32'(8*i) || wr_data_q[i] !== mem_data(SRC + 32'(8*i)))
        $display("FAIL bp_wr%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i],
                 DST + 32'(8*i), mem_data(SRC + 32'(8*i))); else n_pass++;
    end
  endtask

  task automatic test_deferred_start();
    bit tmo, seen;
    int early = 0, hcyc = 0;
    logic [20:0] tag;
    clear_logs(); seed = $urandom; lat = $urandom_range(8, 40); host_lat = 30;
    tag = 21'($urandom_range(1, 16'hFFFF));
    @(posedge CLKH); #1 H_ACT = 1'b1; H_CMD = 1'b1; H_ADDR = 32'h2000_0100; H_BE = 8'h00; H_TAGI = tag;
    @(posedge CLKH); #1 H_ACT = 1'b0; START = 1'b1;
    @(posedge CLKH); #1 START = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLKH);
      if (H_DRDY) begin seen = 1; hcyc = cyc; break; end
      if (BUSY || F_ACT) early++;
    end
    n_checks++; if (!seen) $display("FAIL defer_hdrdy: got no response want one within 60 cycles"); else n_pass++;
    n_checks++; if (H_DTO !== mem_data(32'h2000_0100) || H_TAGO !== tag)
      $display("FAIL defer_hdata: got %h/%h want %h/%h", H_DTO, H_TAGO, mem_data(32'h2000_0100), tag); else n_pass++;
    n_checks++; if (early != 0) $display("FAIL defer_early: got %0d engine cycles before response want 0", early); else n_pass++;
    wait_busy(10, tmo);
    n_checks++; if (tmo) $display("FAIL defer_start: got busy=0 want latched start taken"); else n_pass++;
    wait_idle(2000, tmo);
    n_checks++; if (tmo || DONE !== 1'b1) $display("FAIL defer_finish: got tmo=%b done=%b want 0 1", tmo, DONE); else n_pass++;
    n_checks++; if (rd_addr_q.size() != NQ || rd_addr_q[0] !== SRC || rd_cyc_q[0] <= hcyc)
      $display("FAIL defer_first_read: got n=%0d addr=%h want %0d reads from %h after cyc %0d",
               rd_addr_q.size(), rd_addr_q[0], NQ, SRC, hcyc); else n_pass++;
  endtask

  task automatic test_foreign_tag();
    bit tmo;
    clear_logs(); seed = $urandom; lat = $urandom_range(10, 40); resp_mode = 1;
    pulse_start();
    wait_idle(2000, tmo);
    n_checks++; if (tmo || DONE !== 1'b1) $display("FAIL foreign_finish: got tmo=%b done=%b want 0 1", tmo, DONE); else n_pass++;
    n_checks++; if (wr_data_q.size() != NQ || wr_data_q[0] !== 64'hAAAA)
      $display("FAIL foreign_dbuf: got n=%0d data=%h want %0d writes first %h", wr_data_q.size(), wr_data_q[0], NQ, 64'hAAAA); else n_pass++;
    for (int i = 1; i < NQ && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== mem_data(SRC + 32'(8*i)))
        $display("FAIL foreign_wr%0d: got %h want %h", i, wr_data_q[i], mem_data(SRC + 32'(8*i))); else n_pass++;
    end
    n_checks++; if (hdrdy_viol != 0) $display("FAIL foreign_hdrdy: got %0d busy responses forwarded want 0", hdrdy_viol); else n_pass++;
  endtask

  task automatic test_timeout();
    bit tmo, seen;
    int wcyc = 0;
    clear_logs(); seed = $urandom; lat = $urandom_range(8, 40); resp_mode = 2;
    pulse_start();
    tmo = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLKH);
      if (!BUSY) begin tmo = 0; break; end
      if (!F_ACT) wcyc++;
    end
    n_checks++; if (tmo) $display("FAIL timeout_bound: got busy=1 want idle within 300 cycles"); else n_pass++;
    n_checks++; if (wcyc != TMO + 1) $display("FAIL timeout_cycles: got %0d want %0d", wcyc, TMO + 1); else n_pass++;
    n_checks++; if (ERR !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL timeout_flags: got err=%b done=%b busy=%b want 1 0 0", ERR, DONE, BUSY); else n_pass++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLKH);
      if (H_DRDY) begin seen = 1; break; end
    end
    n_checks++; if (!seen || H_DTO !== mem_data(SRC) || H_TAGO !== RDT)
      $display("FAIL timeout_late_fwd: got seen=%b data=%h tag=%h want 1/%h/%h", seen, H_DTO, H_TAGO, mem_data(SRC), RDT); else n_pass++;
    clear_logs();
    pulse_start();
    n_checks++; if (ERR !== 1'b0 || BUSY !== 1'b1) $display("FAIL timeout_restart: got err=%b busy=%b want 0 1", ERR, BUSY); else n_pass++;
    wait_idle(2000, tmo);
    n_checks++; if (tmo || DONE !== 1'b1 || rd_addr_q.size() != NQ || rd_addr_q[0] !== SRC)
      $display("FAIL timeout_retry: got done=%b n=%0d first=%h want 1 %0d %h", DONE, rd_addr_q.size(), rd_addr_q[0], NQ, SRC); else n_pass++;
  endtask

  task automatic test_reset_midcopy();
    bit tmo;
    clear_logs(); seed = $urandom; lat = $urandom_range(8, 40);
    pulse_start();
    tmo = 1;
    for (int k = 0; k < 500; k++) begin
      @(negedge CLKH);
      if (rd_addr_q.size() == 3) begin tmo = 0; break; end
    end
    n_checks++; if (tmo) $display("FAIL midrst_reach: got %0d reads want 3", rd_addr_q.size()); else n_pass++;
    @(posedge CLKH); #1 RESET = 1'b1;
    #1;
    n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || F_ACT !== 1'b0 || H_NEXT !== 1'b1)
      $display("FAIL midrst_outputs: got busy=%b done=%b err=%b act=%b hnext=%b want 0 0 0 0 1",
               BUSY, DONE, ERR, F_ACT, H_NEXT); else n_pass++;
    @(posedge CLKH); @(posedge CLKH);
    clear_logs();
    #1 RESET = 1'b0;
    wait_busy(5, tmo);
    n_checks++; if (tmo) $display("FAIL midrst_autoboot: got busy=0 want restart"); else n_pass++;
    wait_idle(2000, tmo);
    n_checks++; if (tmo || DONE !== 1'b1 || rd_addr_q.size() != NQ || rd_addr_q[0] !== SRC)
      $display("FAIL midrst_copy: got done=%b n=%0d first=%h want 1 %0d %h", DONE, rd_addr_q.size(), rd_addr_q[0], NQ, SRC); else n_pass++;
    for (int i = 0; i < NQ && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== DST + 32'(8*i) || wr_data_q[i] !== mem_data(SRC + 32'(8*i)))
        $display("FAIL midrst_wr%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i],
                 DST + 32'(8*i), mem_data(SRC + 32'(8*i))); else n_pass++;
    end
    n_checks++; if (hnext_viol != 0 || hdrdy_viol != 0)
      $display("FAIL midrst_host_block: got hnext=%0d hdrdy=%0d want 0 0", hnext_viol, hdrdy_viol); else n_pass++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLKH);
    test_reset();
    test_autoboot();
    test_backpressure();
    test_deferred_start();
    test_foreign_tag();
    test_timeout();
    test_reset_midcopy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_boot_copier.md
# flash_boot_copier

Bootstrap copy engine placed directly upstream of the SPI flash / RAM-BIOS controller on its internal request port. It owns that port during a copy: it reads qwords from the SPI data window and writes each one into the internal buffer RAM. Between copies it passes host requests through transparently. It runs automatically after reset, or on demand via START, and reports BUSY, DONE and a timeout ERR.

## Interface
Parameters:
- SRC_BASE, 32'h20000000, byte address of the first source qword in the SPI read window (bits [2:0] must be 0)
- DST_BASE, 32'h00000000, byte address of the first destination qword in the buffer RAM (bit 24 = 0, bits [2:0] = 0)
- QWORDS, 8064, number of qwords per copy (1..8192); the default leaves the 1024-byte play buffer untouched
- RD_TAG, 21'h030000, tag for engine reads; bits [17:16] = 2'b11 select an 8-byte transfer
- TIMEOUT, 4095, maximum cycles to wait for read data
- AUTOBOOT, 1, start one copy automatically after reset release

Ports:
- CLKH  in  1  clock; everything is on its rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  single-cycle copy request
- BUSY  out  1  copy in progress
- DONE  out  1  sticky; set when a copy completes, cleared by the next accepted start
- ERR  out  1  sticky; set on read timeout, cleared by the next accepted start
- H_ACT, H_CMD  in  1  host request; CMD=1 is a read
- H_ADDR  in  32, H_BE  in  8 (active-low byte enables), H_DTI  in  64, H_TAGI  in  21
- H_NEXT  out  1  host may issue a request this cycle
- H_DRDY  out  1, H_DTO  out  64, H_TAGO  out  21  host read response
- F_ACT, F_CMD  out  1, F_ADDR  out  32, F_BE  out  8, F_DTI  out  64, F_TAGI  out  21  request to the flash controller
- F_NEXT  in  1  flash controller can accept a request
- F_DRDY  in  1, F_DTO  in  64, F_TAGO  in  21  flash controller read response

## Operation
- A request transfers on any cycle where F_ACT and F_NEXT are both 1.
- Host pass-through, when BUSY=0:
  - the F_* request outputs equal the H_* inputs (combinational mux);
  - H_NEXT = F_NEXT;
  - H_DRDY/H_DTO/H_TAGO equal F_DRDY/F_DTO/F_TAGO.
- Host read tracking: a 1-bit PEND flag is set on a transferred host read and cleared on F_DRDY.
- States:
  - IDLE
    - Enter RD_REQ when a start is pending and PEND=0.
    - A start is pending on a START pulse, or for one cycle after reset release if AUTOBOOT=1.
    - A start that arrives while PEND=1 is latched and taken once PEND clears.
    - Leaving IDLE sets BUSY, clears DONE and ERR, and sets IDX=0.
  - RD_REQ
    - Drive F_ACT=1, F_CMD=1, F_ADDR=SRC_BASE+8*IDX, F_BE=8'h00, F_TAGI=RD_TAG, F_DTI=0.
    - Hold these until F_NEXT=1, then go to RD_WAIT.
  - RD_WAIT
    - F_ACT=0.
    - On F_DRDY with F_TAGO==RD_TAG: latch F_DTO into DBUF and go to WR_REQ.
    - F_DRDY with any other tag is ignored.
    - A 13-bit wait counter starts at 0; if it reaches TIMEOUT, set ERR and go to IDLE.
  - WR_REQ
    - Drive F_ACT=1, F_CMD=0, F_ADDR=DST_BASE+8*IDX, F_BE=8'h00, F_DTI=DBUF, F_TAGI=0.
    - Hold until F_NEXT=1.
    - Then, if IDX==QWORDS-1, set DONE and go to IDLE; otherwise IDX=IDX+1 and go to RD_REQ.
- BUSY = (state != IDLE).
- While BUSY=1:
  - H_NEXT=0 and H_DRDY=0;
  - the host inputs are ignored.
- Address arithmetic: IDX is 13 bits and is zero-extended; 8*IDX is IDX<<3; additions are 32-bit modulo.
- A START pulse while BUSY=1 is ignored and is not latched.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, ERR=0, PEND=0, IDX=0, DBUF=0.
  - F_ACT is then 0 unless H_ACT passes through.
  - H_NEXT follows F_NEXT.
- START sampled high in IDLE with PEND=0: BUSY=1 and F_ACT=1 on the next cycle.
- Each qword costs 1 read-issue cycle (minimum), the controller read latency, 1 DBUF-capture edge, and 1 write cycle (minimum, when F_NEXT=1).
- DONE and BUSY=0 appear together, in the cycle after the final write transfers.
- The host regains H_NEXT in that same cycle.
- RESET asserted mid-copy: all state returns to its reset value immediately (asynchronous).
  - A partially copied region is left as is.
  - After release, AUTOBOOT restarts the copy from IDX=0.
- Timeout: ERR=1 and BUSY=0 in the cycle after the wait counter reaches TIMEOUT.
  - A late F_DRDY that arrives afterwards is forwarded to the host port as a normal pass-through response.

## Test plan
- Autoboot, QWORDS=4, model latency 20 cycles:
  - release RESET;
  - expect reads at 20000000, 20000008, 20000010, 20000018, each followed by a write to 0, 8, 10h, 18h carrying the returned data, with BE=00;
  - expect DONE=1 and BUSY=0 after the 4th write;
  - expect H_NEXT=0 throughout the copy.
- Backpressure: hold F_NEXT=0 for 7 cycles during RD_REQ and WR_REQ; expect F_ACT, F_ADDR and F_DTI stable, and each request transferred exactly once.
- Deferred start: issue a host read to 20000100h with the response delayed 30 cycles, and pulse START one cycle later; expect no engine request until after H_DRDY returns the host data, then the copy begins.
- Foreign tag: during RD_WAIT, inject F_DRDY with tag 0 and data 1111h, then the RD_TAG response with data AAAAh; expect DBUF=AAAAh to be written.
- Timeout, TIMEOUT=100: never return data; expect ERR=1, DONE=0 and BUSY=0 at cycle 101 of the wait; then a START pulse clears ERR and retries from IDX=0.
- Reset mid-copy at IDX=2: expect all outputs at their reset values in the same cycle, and the copy restarting from 20000000h after release.
